// File: rtl/wsi_req_pkg.sv
// Shared field layout and command codes for the WSI request word.
// Bit offsets and the state type used by the request unpacker.
package wsi_req_pkg;

    localparam int REQ_W       = 61;
    localparam int MCMD_HI     = 60;
    localparam int MCMD_LO     = 58;
    localparam int LAST_BIT    = 57;
    localparam int PRECISE_BIT = 56;
    localparam int BLEN_HI     = 55;
    localparam int BLEN_LO     = 44;
    localparam int MDATA_HI    = 43;
    localparam int MDATA_LO    = 12;
    localparam int BYTEEN_HI   = 11;
    localparam int BYTEEN_LO   = 8;
    localparam int INFO_HI     = 7;
    localparam int INFO_LO     = 0;

    localparam logic [2:0] CMD_IDLE = 3'b000;
    localparam logic [2:0] CMD_WR   = 3'b001;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

endpackage

// File: rtl/wsi_req_unpacker.sv
// Unpacks WSI request words from a FIFO into a registered output stage,
// tracking burst framing and flagging protocol errors.
module wsi_req_unpacker
    import wsi_req_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                 wciS0_Clk,
    input  logic                 wciS0_Rst,
    input  logic [REQ_W-1:0]     fifo_dout,
    input  logic                 fifo_not_empty,
    output logic                 fifo_deq,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_data,
    output logic [3:0]           out_byteen,
    output logic [7:0]           out_reqinfo,
    output logic                 out_first,
    output logic                 out_last,
    output logic                 burst_err,
    output logic [CNT_W-1:0]     err_count,
    output logic [CNT_W-1:0]     burst_count,
    output logic                 busy
);

    logic [2:0]  req_cmd;
    logic        req_last;
    logic        req_precise;
    logic [11:0] req_blen;

    assign req_cmd     = fifo_dout[MCMD_HI:MCMD_LO];
    assign req_last    = fifo_dout[LAST_BIT];
    assign req_precise = fifo_dout[PRECISE_BIT];
    assign req_blen    = fifo_dout[BLEN_HI:BLEN_LO];

    state_e      state, state_nxt;
    logic [11:0] wcnt;
    logic [11:0] blen;
    logic        precise;

    logic        is_wr;
    logic        opening;
    logic        cur_precise;
    logic [11:0] cur_len;
    logic [11:0] idx;
    logic        len_hit;
    logic        ends;
    logic        err;

    // State register
    always_ff @(posedge wciS0_Clk) begin
        if (wciS0_Rst) state <= ST_IDLE;
        else           state <= state_nxt;
    end

    // Next state and per-word decode; a zero precise length behaves as one word
    always_comb begin
        is_wr       = (req_cmd == CMD_WR);
        opening     = (state == ST_IDLE);
        cur_precise = opening ? req_precise : precise;
        cur_len     = opening ? ((req_blen == '0) ? 12'd1 : req_blen) : blen;
        idx         = opening ? 12'd1 : (wcnt + 12'd1);
        len_hit     = cur_precise && (idx == cur_len);
        ends        = req_last || len_hit;
        err         = 1'b0;
        state_nxt   = state;
        if (fifo_deq) begin
            if (is_wr) begin
                state_nxt = ends ? ST_IDLE : ST_BURST;
                err = (opening && req_precise && (req_blen == '0))
                   || (cur_precise && req_last && !len_hit)
                   || (len_hit && !req_last);
            end else begin
                err = (req_cmd != CMD_IDLE);
            end
        end
    end

    // Output decode
    always_comb begin
        fifo_deq = fifo_not_empty && !wciS0_Rst && (!out_valid || out_ready);
        busy     = (state == ST_BURST);
    end

    // Burst tracking, counters and output register
    always_ff @(posedge wciS0_Clk) begin
        if (wciS0_Rst) begin
            wcnt        <= '0;
            blen        <= '0;
            precise     <= 1'b0;
            burst_err   <= 1'b0;
            err_count   <= '0;
            burst_count <= '0;
            out_valid   <= 1'b0;
            out_first   <= 1'b0;
            out_last    <= 1'b0;
            out_data    <= '0;
            out_byteen  <= '0;
            out_reqinfo <= '0;
        end else begin
            burst_err <= err;
            if (err && (err_count != '1))
                err_count <= err_count + CNT_W'(1);
            if (fifo_deq && is_wr) begin
                wcnt <= idx;
                if (opening) begin
                    precise <= req_precise;
                    blen    <= req_precise ? cur_len : 12'd0;
                end
                if (ends)
                    burst_count <= burst_count + CNT_W'(1);
                out_valid   <= 1'b1;
                out_first   <= opening;
                out_last    <= ends;
                out_data    <= fifo_dout[MDATA_HI:MDATA_LO];
                out_byteen  <= fifo_dout[BYTEEN_HI:BYTEEN_LO];
                out_reqinfo <= fifo_dout[INFO_HI:INFO_LO];
            end else if (fifo_deq || (out_valid && out_ready)) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/wsi_req_unpacker.md
WSI_REQ_UNPACKER -- requirements
Module: wsi_req_unpacker

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the error and burst counters.
REQ-002 SHALL have port wciS0_Clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port wciS0_Rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port fifo_dout  input  61  request word: [60:58] MCmd, [57] ReqLast, [56] BurstPrecise, [55:44] BurstLength, [43:12] MData, [11:8] MByteEn, [7:0] MReqInfo.
REQ-005 SHALL have port fifo_not_empty  input  1  high when fifo_dout holds a valid word.
REQ-006 SHALL have port fifo_deq  output  1  dequeue strobe to the request FIFO.
REQ-007 SHALL have port out_valid  output  1  output register holds a word.
REQ-008 SHALL have port out_ready  input  1  consumer accepts the word when out_valid & out_ready.
REQ-009 SHALL have port out_data  output  32  MData of the held word.
REQ-010 SHALL have port out_byteen  output  4  MByteEn of the held word.
REQ-011 SHALL have port out_reqinfo  output  8  MReqInfo of the held word.
REQ-012 SHALL have port out_first  output  1  held word is the first word of a burst.
REQ-013 SHALL have port out_last  output  1  held word closes a burst.
REQ-014 SHALL have port burst_err  output  1  one-cycle pulse on any protocol error.
REQ-015 SHALL have port err_count  output  CNT_W  saturating count of errors.
REQ-016 SHALL have port burst_count  output  CNT_W  wrapping count of completed bursts.
REQ-017 SHALL have port busy  output  1  high while state is BURST.

Function
REQ-018 SHALL drive fifo_deq = fifo_not_empty & !wciS0_Rst & (!out_valid | out_ready), combinationally.
REQ-019 SHALL load the output register on the clock after fifo_deq is high (latency 1), sustaining one word per cycle.
REQ-020 SHALL clear out_valid on out_valid & out_ready when there is no concurrent fifo_deq.
REQ-021 SHALL pass only words with MCmd = 3'b001 (WR); any other MCmd is dequeued, dropped, and leaves state unchanged.
REQ-022 SHALL count a nonzero non-WR MCmd as an error; MCmd = 0 is dropped silently.
REQ-023 SHALL implement states IDLE and BURST, with a 12-bit word counter and a 12-bit captured length.
REQ-024 SHALL, in IDLE on a WR word: set out_first=1, word counter=1, and capture BurstLength when BurstPrecise=1.
REQ-025 SHALL treat a precise burst with BurstLength=0 as length 1 and flag an error.
REQ-026 SHALL, on a WR word in IDLE or BURST, end the burst (out_last=1, burst_count+1, go IDLE) when ReqLast=1, or when the burst is precise and counter equals the captured length.
REQ-027 SHALL otherwise go to or remain in BURST and increment the counter; out_first=0 for every non-opening word.
REQ-028 SHALL flag an error when a precise burst has ReqLast=1 with counter != length, or reaches the length with ReqLast=0; the burst still ends there.
REQ-029 SHALL treat the next word after a forced end as the opening word of a new burst.
REQ-030 SHALL pulse burst_err for exactly the cycle after the offending word is dequeued; simultaneous errors count once.
REQ-031 SHALL hold err_count at all-ones once saturated; burst_count SHALL wrap modulo 2^CNT_W.
REQ-032 SHALL hold out_* fields stable while out_valid & !out_ready.

Reset
REQ-033 SHALL, with wciS0_Rst high, set state IDLE, counters, captured length, out_valid, out_first, out_last, burst_err, err_count, burst_count to 0; out_data, out_byteen, out_reqinfo to 0.
REQ-034 SHALL hold fifo_deq low during reset; a burst in progress is abandoned without error or count.

Structure
REQ-035 SHALL place field bit offsets, the 61-bit word width and CMD_WR in shared package wsi_req_pkg.
REQ-036 SHALL be a single module with no sub-module.

Verification
REQ-037 SHALL cover: precise burst len=4, ReqLast on word 4, out_ready=1 -> 4 outputs on consecutive cycles, first on word 1, last on word 4, burst_count=1, no error.
REQ-038 SHALL cover: precise len=3, ReqLast on word 2 -> last on word 2, one burst_err pulse, err_count=1; word 3 emerges with out_first=1.
REQ-039 SHALL cover: imprecise burst with BurstLength=5, ReqLast on word 7 -> 7 outputs, last on word 7, no error.
REQ-040 SHALL cover: out_ready low for 3 cycles mid-burst with FIFO non-empty -> fifo_deq low, outputs stable, no word lost or duplicated.
REQ-041 SHALL cover: MCmd=3'b010 word between bursts -> no output, err_count+1; reset asserted on word 2 of a len=4 burst -> all outputs zero, next word opens a new burst.
